ddr3_cmd_sequencer: RTL and testbench

DDR3_CMD_SEQUENCER -- requirements
Module: ddr3_cmd_sequencer

---
 rtl/ddr3_pkg.sv | 38 +++
 rtl/ddr3_refresh_timer.sv | 34 +++
 rtl/ddr3_cmd_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_ddr3_cmd_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_pkg.sv
// Shared definitions for the DDR3 command sequencer: command encodings,
// FSM state enum and default timing parameters.
package ddr3_pkg;

  // {CS_N, RAS_N, CAS_N, WE_N}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_IDLE,
    ST_ACT,
    ST_TRCD,
    ST_RDCMD,
    ST_WRCMD,
    ST_CASWAIT,
    ST_BURST,
    ST_TWR,
    ST_PRE,
    ST_TRP,
    ST_REF,
    ST_TRFC
  } state_t;

  localparam int DEF_T_INIT = 16;
  localparam int DEF_T_RCD  = 5;
  localparam int DEF_CL     = 5;
  localparam int DEF_CWL    = 5;
  localparam int DEF_T_WR   = 4;
  localparam int DEF_T_RP   = 5;
  localparam int DEF_T_RFC  = 20;
  localparam int DEF_T_REFI = 780;

endpackage

// File: rtl/ddr3_refresh_timer.sv
// Free-running refresh interval counter with a sticky pending flag that the
// sequencer clears when it issues REF.
module ddr3_refresh_timer
  import ddr3_pkg::*;
#(
  parameter int T_REFI = DEF_T_REFI
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic pending
);

  localparam logic [15:0] LAST = 16'(T_REFI - 1);

  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 16'd0;
      pending <= 1'b0;
    end else begin
      if (en) begin
        if (cnt == LAST) cnt <= 16'd0;
        else             cnt <= cnt + 16'd1;
      end
      // An expiry while already pending collapses into the existing request.
      if (clr)                      pending <= 1'b0;
      else if (en && cnt == LAST)   pending <= 1'b1;
    end
  end

endmodule

// File: rtl/ddr3_cmd_sequencer.sv
// Single-bank-at-a-time DDR3 command sequencer with closed-page policy,
// 8-beat bursts on an 8-bit data path and periodic auto-refresh.
module ddr3_cmd_sequencer
  import ddr3_pkg::*;
#(
  parameter int T_INIT = DEF_T_INIT,
  parameter int T_RCD  = DEF_T_RCD,
  parameter int CL     = DEF_CL,
  parameter int CWL    = DEF_CWL,
  parameter int T_WR   = DEF_T_WR,
  parameter int T_RP   = DEF_T_RP,
  parameter int T_RFC  = DEF_T_RFC,
  parameter int T_REFI = DEF_T_REFI
) (
  input  logic        CPU_CLK,
  input  logic        RESET,
  input  logic        ADDR_VALID,
  input  logic        CMD,
  input  logic [2:0]  BA,
  input  logic [14:0] ADDR,
  input  logic [9:0]  COL,
  input  logic [63:0] WR_DATA,
  output logic        CMD_RDY,
  output logic [63:0] RD_DATA,
  output logic        RD_VALID,
  output logic        CKE_N,
  output logic        CS_N,
  output logic        RAS_N,
  output logic        CAS_N,
  output logic        WE_N,
  output logic [2:0]  MBA,
  output logic [14:0] MADDR,
  output logic [9:0]  MCOL,
  output logic [7:0]  MWR_DATA,
  output logic        DQ_OE,
  input  logic [7:0]  MRD_DATA,
  output state_t      dbg_state
);

  // Wait states count from 1 on entry, so each *_LAST is the final count
  // before the next command; multi-cycle waits assume parameters >= 2.
  localparam logic [7:0] INIT_LAST = 8'(T_INIT);
  localparam logic [7:0] INIT_CKE  = 8'(T_INIT - 1);
  localparam logic [7:0] RCD_LAST  = 8'(T_RCD - 1);
  localparam logic [7:0] CL_LAST   = 8'(CL - 1);
  localparam logic [7:0] CWL_LAST  = 8'(CWL - 1);
  localparam logic [7:0] WR_LAST   = 8'(T_WR - 1);
  localparam logic [7:0] RP_LAST   = 8'(T_RP - 1);
  localparam logic [7:0] RFC_LAST  = 8'(T_RFC);

  state_t      state;
  logic [7:0]  cnt;
  logic [3:0]  cmd_q;
  logic        lat_wr;
  logic [9:0]  lat_col;
  logic [63:0] wr_shift;
  logic [63:0] rd_shift;
  logic        ref_pending;
  logic        ref_clr;
  logic        timer_en;
  logic [7:0]  cas_last;

  assign timer_en = (state != ST_INIT);
  assign ref_clr  = (state == ST_IDLE) && ref_pending;
  assign cas_last = lat_wr ? CWL_LAST : CL_LAST;
  assign {CS_N, RAS_N, CAS_N, WE_N} = cmd_q;
  assign dbg_state = state;

  // Handshake: a request transfers on a rising edge where ADDR_VALID and
  // CMD_RDY are both 1; the requester holds ADDR_VALID and its fields stable
  // until then. CMD_RDY never depends on ADDR_VALID.
  assign CMD_RDY = (state == ST_IDLE) && !ref_pending;

  ddr3_refresh_timer #(.T_REFI(T_REFI)) u_refresh_timer (
    .clk     (CPU_CLK),
    .rst     (RESET),
    .en      (timer_en),
    .clr     (ref_clr),
    .pending (ref_pending)
  );

  always_ff @(posedge CPU_CLK) begin
    if (RESET) begin
      state    <= ST_INIT;
      cnt      <= 8'd0;
      cmd_q    <= CMD_NOP;
      CKE_N    <= 1'b1;
      MBA      <= 3'd0;
      MADDR    <= 15'd0;
      MCOL     <= 10'd0;
      MWR_DATA <= 8'd0;
      DQ_OE    <= 1'b0;
      RD_VALID <= 1'b0;
      RD_DATA  <= 64'd0;
      lat_wr   <= 1'b0;
      lat_col  <= 10'd0;
      wr_shift <= 64'd0;
      rd_shift <= 64'd0;
    end else begin
      cmd_q    <= CMD_NOP;
      RD_VALID <= 1'b0;
      case (state)
        ST_INIT: begin
          if (cnt == INIT_LAST) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 8'd1;
            if (cnt == INIT_CKE) CKE_N <= 1'b0;
          end
        end
        ST_IDLE: begin
          // Refresh wins over a request presented in the same cycle.
          if (ref_pending) begin
            state <= ST_REF;
            cmd_q <= CMD_REF;
          end else if (ADDR_VALID) begin
            state    <= ST_ACT;
            cmd_q    <= CMD_ACT;
            MBA      <= BA;
            MADDR    <= ADDR;
            lat_wr   <= CMD;
            lat_col  <= COL;
            wr_shift <= WR_DATA;
          end
        end
        ST_ACT: begin
          state <= ST_TRCD;
          cnt   <= 8'd1;
        end
        ST_TRCD: begin
          if (cnt == RCD_LAST) begin
            state <= lat_wr ? ST_WRCMD : ST_RDCMD;
            cmd_q <= lat_wr ? CMD_WR : CMD_RD;
            MCOL  <= lat_col;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_RDCMD, ST_WRCMD: begin
          state <= ST_CASWAIT;
          cnt   <= 8'd1;
        end
        ST_CASWAIT: begin
          if (cnt == cas_last) begin
            state <= ST_BURST;
            cnt   <= 8'd0;
            if (lat_wr) begin
              DQ_OE    <= 1'b1;
              MWR_DATA <= wr_shift[7:0];
              wr_shift <= wr_shift >> 8;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_BURST: begin
          if (lat_wr) begin
            if (cnt == 8'd7) begin
              DQ_OE    <= 1'b0;
              MWR_DATA <= 8'd0;
              state    <= ST_TWR;
              cnt      <= 8'd1;
            end else begin
              MWR_DATA <= wr_shift[7:0];
              wr_shift <= wr_shift >> 8;
              cnt      <= cnt + 8'd1;
            end
          end else begin
            // Beats shift in from the top so beat 0 ends up in the low byte.
            rd_shift <= {MRD_DATA, rd_shift[63:8]};
            if (cnt == 8'd7) begin
              RD_DATA  <= {MRD_DATA, rd_shift[63:8]};
              RD_VALID <= 1'b1;
              state    <= ST_PRE;
              cmd_q    <= CMD_PRE;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        ST_TWR: begin
          if (cnt == WR_LAST) begin
            state <= ST_PRE;
            cmd_q <= CMD_PRE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_PRE: begin
          state <= ST_TRP;
          cnt   <= 8'd1;
        end
        ST_TRP: begin
          if (cnt == RP_LAST) state <= ST_IDLE;
          else                cnt   <= cnt + 8'd1;
        end
        ST_REF: begin
          state <= ST_TRFC;
          cnt   <= 8'd1;
        end
        ST_TRFC: begin
          if (cnt == RFC_LAST) state <= ST_IDLE;
          else                 cnt   <= cnt + 8'd1;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_cmd_sequencer.sv
// Randomized bench for ddr3_cmd_sequencer against a transaction-level timing
// model that schedules every expected bus event per cycle.
module tb_ddr3_cmd_sequencer;
  import ddr3_pkg::*;

  localparam int T_INIT = 16;
  localparam int T_RCD  = 5;
  localparam int CL     = 5;
  localparam int CWL    = 5;
  localparam int T_WR   = 4;
  localparam int T_RP   = 5;
  localparam int T_RFC  = 20;
  localparam int T_REFI = 780;

  logic        CPU_CLK;
  logic        RESET;
  logic        ADDR_VALID;
  logic        CMD;
  logic [2:0]  BA;
  logic [14:0] ADDR;
  logic [9:0]  COL;
  logic [63:0] WR_DATA;
  logic        CMD_RDY;
  logic [63:0] RD_DATA;
  logic        RD_VALID;
  logic        CKE_N, CS_N, RAS_N, CAS_N, WE_N;
  logic [2:0]  MBA;
  logic [14:0] MADDR;
  logic [9:0]  MCOL;
  logic [7:0]  MWR_DATA;
  logic        DQ_OE;
  logic [7:0]  MRD_DATA;
  state_t      dbg_state;

  ddr3_cmd_sequencer #(
    .T_INIT(T_INIT), .T_RCD(T_RCD), .CL(CL), .CWL(CWL),
    .T_WR(T_WR), .T_RP(T_RP), .T_RFC(T_RFC), .T_REFI(T_REFI)
  ) dut (
    .CPU_CLK(CPU_CLK), .RESET(RESET), .ADDR_VALID(ADDR_VALID), .CMD(CMD),
    .BA(BA), .ADDR(ADDR), .COL(COL), .WR_DATA(WR_DATA), .CMD_RDY(CMD_RDY),
    .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .CKE_N(CKE_N), .CS_N(CS_N),
    .RAS_N(RAS_N), .CAS_N(CAS_N), .WE_N(WE_N), .MBA(MBA), .MADDR(MADDR),
    .MCOL(MCOL), .MWR_DATA(MWR_DATA), .DQ_OE(DQ_OE), .MRD_DATA(MRD_DATA),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial CPU_CLK = 1'b0;
  always #5 CPU_CLK = ~CPU_CLK;

  // ---------------- scoreboard state ----------------
  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int t       = 0;

  int m_free, m_due, last_pre, obs_ref;
  bit m_pending;
  logic [3:0]  exp_cmd[int];
  logic [2:0]  exp_ba[int];
  logic [14:0] exp_addr[int];
  logic [9:0]  exp_col[int];
  logic [7:0]  exp_wr[int];
  logic [7:0]  rd_beat[int];
  bit          exp_rdv[int];
  logic [63:0] exp_q[$];
  logic [63:0] rd_hold;

  bit          req_v = 0;
  bit          req_wr, req_rst_test;
  logic [2:0]  req_ba;
  logic [14:0] req_addr;
  logic [9:0]  req_col;
  logic [63:0] req_data, req_rd;
  int          n_acc = 0;
  bit          rst_req_made = 0, rst_armed = 0, rst_pend = 0, rst_done = 0, done = 0;
  int          rst_at;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_cmd.delete(); exp_ba.delete(); exp_addr.delete(); exp_col.delete();
    exp_wr.delete(); rd_beat.delete(); exp_rdv.delete(); exp_q.delete();
    cyc       = 0;
    m_free    = T_INIT + 1;
    m_due     = T_INIT + 1 + T_REFI;
    m_pending = 0;
    last_pre  = -1;
    rd_hold   = 64'd0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input bit wr, input logic [2:0] ba, input logic [14:0] addr,
                         input logic [9:0] col, input logic [63:0] data, input logic [63:0] beats);
    req_v = 1; req_wr = wr; req_ba = ba; req_addr = addr; req_col = col;
    req_data = data; req_rd = beats; req_rst_test = 0;
  endtask

  task automatic set_rand_req(input bit force_rd);
    set_req(force_rd ? 1'b0 : 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            15'($urandom_range(0, 32767)), 10'($urandom_range(0, 1023)),
            {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  task automatic gen_request();
    if (req_v) return;
    if (n_acc == 0)
      set_req(1, 3'd2, 15'h1234, 10'h005, 64'h0807060504030201, 64'd0);
    else if (n_acc == 1)
      set_req(0, 3'd5, 15'h0ABC, 10'h123, 64'd0, 64'hA7A6A5A4A3A2A1A0);
    else if (t < 740 && $urandom_range(0, 3) == 0)
      set_rand_req(0);
    else if (t >= 797 && t < 800)
      set_rand_req(0);
    else if (t >= 830 && t < 900 && $urandom_range(0, 1) == 0)
      set_rand_req(0);
    else if (t >= 900 && t < 980)
      set_rand_req(1);
    else if (t >= 1000 && !rst_req_made) begin
      set_req(1, 3'd3, 15'h7F00, 10'h3C0, {$urandom, $urandom}, 64'd0);
      req_rst_test = 1;
      rst_req_made = 1;
    end
  endtask

  task automatic drive_inputs();
    ADDR_VALID = req_v;
    if (req_v) begin
      CMD = req_wr; BA = req_ba; ADDR = req_addr; COL = req_col; WR_DATA = req_data;
    end else begin
      CMD = 1'($urandom_range(0, 1)); BA = 3'($urandom_range(0, 7));
      ADDR = 15'($urandom_range(0, 32767)); COL = 10'($urandom_range(0, 1023));
      WR_DATA = {$urandom, $urandom};
    end
    MRD_DATA = rd_beat.exists(cyc) ? rd_beat[cyc] : 8'($urandom_range(0, 255));
  endtask

  // Schedules all bus events of an accepted request from the timing rules.
  task automatic schedule(input int a);
    int k, b, pre;
    k = a + 1 + T_RCD;
    exp_cmd[a + 1] = CMD_ACT; exp_ba[a + 1] = req_ba; exp_addr[a + 1] = req_addr;
    exp_cmd[k] = req_wr ? CMD_WR : CMD_RD; exp_ba[k] = req_ba; exp_col[k] = req_col;
    b = k + (req_wr ? CWL : CL);
    for (int i = 0; i < 8; i++) begin
      if (req_wr) exp_wr[b + i] = req_data[8*i +: 8];
      else        rd_beat[b + i] = req_rd[8*i +: 8];
    end
    if (req_wr) pre = b + 7 + T_WR;
    else begin
      pre = b + 8;
      exp_rdv[pre] = 1;
      exp_q.push_back(req_rd);
    end
    exp_cmd[pre] = CMD_PRE;
    m_free = pre + T_RP;
    if (req_rst_test) begin
      rst_armed = 1;
      rst_at = b + 3;
    end
  endtask

  task automatic step_model();
    logic [3:0] cmd_obs, cmd_exp;
    bit exp_rdy, clr;
    cmd_obs = {CS_N, RAS_N, CAS_N, WE_N};
    cmd_exp = exp_cmd.exists(cyc) ? exp_cmd[cyc] : CMD_NOP;
    check("cmd", cmd_obs, cmd_exp);
    if (cmd_exp == CMD_ACT) begin
      check("act_ba", MBA, exp_ba[cyc]);
      check("act_row", MADDR, exp_addr[cyc]);
    end
    if (cmd_exp == CMD_RD || cmd_exp == CMD_WR) begin
      check("cas_ba", MBA, exp_ba[cyc]);
      check("cas_col", MCOL, exp_col[cyc]);
    end
    if (cmd_obs == CMD_ACT && last_pre >= 0) check("act_after_pre", (cyc - last_pre) >= T_RP, 1);
    if (cmd_obs == CMD_PRE) last_pre = cyc;
    if (cmd_obs == CMD_REF) obs_ref++;
    if (cyc == 0) check("state_init", dbg_state, ST_INIT);
    check("cke_n", CKE_N, cyc < T_INIT);
    check("dq_oe", DQ_OE, exp_wr.exists(cyc));
    check("mwr_data", MWR_DATA, exp_wr.exists(cyc) ? exp_wr[cyc] : 8'd0);
    check("rd_valid", RD_VALID, exp_rdv.exists(cyc));
    if (exp_rdv.exists(cyc) && exp_q.size() > 0) rd_hold = exp_q.pop_front();
    check("rd_data", RD_DATA, rd_hold);

    exp_rdy = (cyc >= m_free) && !m_pending;
    check("cmd_rdy", CMD_RDY, exp_rdy);
    clr = (cyc >= m_free) && m_pending;
    if (clr) begin
      exp_cmd[cyc + 1] = CMD_REF;
      m_free = cyc + 2 + T_RFC;
    end else if (exp_rdy && req_v) begin
      schedule(cyc);
      req_v = 0;
      n_acc++;
    end
    if (cyc + 1 == m_due) begin
      m_due += T_REFI;
      if (!clr) m_pending = 1;
    end
    if (clr) m_pending = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    obs_ref = 0;
    RESET = 1'b1; ADDR_VALID = 1'b0; CMD = 1'b0; BA = '0; ADDR = '0; COL = '0;
    WR_DATA = '0; MRD_DATA = '0;
    model_reset();
    repeat (3) @(posedge CPU_CLK);
    #1;
    RESET = 1'b0;
    drive_inputs();
    @(negedge CPU_CLK);
    step_model();
    while (!done && t < 1500) begin
      @(posedge CPU_CLK);
      #1;
      t++;
      if (rst_pend) begin
        rst_pend = 0;
        RESET = 1'b0;
        model_reset();
        rst_done = 1;
      end else begin
        cyc++;
      end
      if (!rst_done) gen_request();
      drive_inputs();
      if (rst_armed && cyc == rst_at) begin
        RESET = 1'b1;
        rst_pend = 1;
        rst_armed = 0;
      end
      @(negedge CPU_CLK);
      step_model();
      if (rst_done && cyc >= T_INIT + 8) done = 1;
    end
    check("reset_test_reached", rst_done, 1);
    check("refresh_seen", obs_ref != 0, 1);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
